// File: rtl/pifo_pkg.sv
// Shared widths and slot record layout for the scheduler rank path and the PIFO sorter.
package pifo_pkg;

    localparam int unsigned RANK_WIDTH = 16;
    localparam int unsigned META_WIDTH = 16;
    localparam int unsigned SLOT_WIDTH = 1 + RANK_WIDTH + META_WIDTH;

    typedef struct packed {
        logic                  vld;
        logic [RANK_WIDTH-1:0] rank;
        logic [META_WIDTH-1:0] meta;
    } slot_t;

endpackage

// File: rtl/pifo_slot.sv
// One storage slot of the sorted register array; {vld, rank, meta} packed MSB first.
module pifo_slot
    import pifo_pkg::*;
#(
    parameter int unsigned RANK_WIDTH = pifo_pkg::RANK_WIDTH,
    parameter int unsigned META_WIDTH = pifo_pkg::META_WIDTH
) (
    input  logic                             clk,
    input  logic                             i_hold,
    input  logic                             i_shift_up,
    input  logic                             i_shift_down,
    input  logic                             i_load_new,
    input  logic                             i_clear,
    input  logic [RANK_WIDTH+META_WIDTH:0]   i_lo,
    input  logic [RANK_WIDTH+META_WIDTH:0]   i_hi,
    input  logic [RANK_WIDTH+META_WIDTH:0]   i_new,
    output logic [RANK_WIDTH+META_WIDTH:0]   o_slot,
    output logic                             o_le_c
);

    localparam int unsigned SW = 1 + RANK_WIDTH + META_WIDTH;

    logic [SW-1:0] r_slot;

    // Invalid slots are always all-zero, so the head reads 0 when empty.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_slot <= '0;
        end else if (i_load_new) begin
            r_slot <= i_new;
        end else if (i_shift_down) begin
            r_slot <= i_hi;
        end else if (i_shift_up) begin
            r_slot <= i_lo;
        end else if (i_hold) begin
            r_slot <= r_slot;
        end
    end

    assign o_slot = r_slot;
    assign o_le_c = r_slot[SW-1] &&
                    (r_slot[RANK_WIDTH+META_WIDTH-1:META_WIDTH] <= i_new[RANK_WIDTH+META_WIDTH-1:META_WIDTH]);

endmodule

// File: rtl/pifo_reg_sorter.sv
// Register-array PIFO: sorted insert from the rank pipeline, min-rank head dequeued by egress.
module pifo_reg_sorter
    import pifo_pkg::*;
#(
    parameter int unsigned RANK_WIDTH = pifo_pkg::RANK_WIDTH,
    parameter int unsigned META_WIDTH = pifo_pkg::META_WIDTH,
    parameter int unsigned L2_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [RANK_WIDTH-1:0] rank_in,
    input  logic [META_WIDTH-1:0] meta_in,
    output logic                  in_remove,
    input  logic                  deq,
    output logic                  valid_out,
    output logic [RANK_WIDTH-1:0] rank_out,
    output logic [META_WIDTH-1:0] meta_out,
    output logic                  full,
    output logic [L2_DEPTH:0]     count
);

    localparam int unsigned DEPTH = 1 << L2_DEPTH;
    localparam int unsigned CW    = L2_DEPTH + 1;
    localparam int unsigned SW    = 1 + RANK_WIDTH + META_WIDTH;

    logic [SW-1:0]    w_slot [DEPTH];
    logic [DEPTH-1:0] w_le;
    logic [DEPTH-1:0] w_hold, w_up, w_dn, w_load, w_clr;
    logic [SW-1:0]    w_new;
    logic [CW-1:0]    w_pos, w_ins_pos, w_count_nxt;
    logic             w_deq_eff, w_ins;
    logic [CW-1:0]    r_count;
    logic             r_full;

    assign w_new     = {1'b1, rank_in, meta_in};
    assign w_deq_eff = deq & w_slot[0][SW-1];
    assign w_ins     = rst & in_valid & (~r_full | w_deq_eff);
    assign in_remove = w_ins;

    // Compare bits form a thermometer code; its population count is the insert position.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pos = w_pos + CW'(w_le[i]);
        end
    end

    // With a simultaneous dequeue the old head drops out, so the slot index is one lower.
    assign w_ins_pos = (w_pos != '0) ? w_pos - CW'(1) : w_pos;

    // Per-slot control decode.
    always_comb begin
        w_hold = '0;
        w_up   = '0;
        w_dn   = '0;
        w_load = '0;
        w_clr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                w_clr[i] = 1'b1;
            end else if (w_ins && w_deq_eff) begin
                if (CW'(i) < w_ins_pos)       w_dn[i]   = 1'b1;
                else if (CW'(i) == w_ins_pos) w_load[i] = 1'b1;
                else                          w_hold[i] = 1'b1;
            end else if (w_ins) begin
                if (CW'(i) < w_pos)           w_hold[i] = 1'b1;
                else if (CW'(i) == w_pos)     w_load[i] = 1'b1;
                else if (CW'(i) <= r_count)   w_up[i]   = 1'b1;
                else                          w_hold[i] = 1'b1;
            end else if (w_deq_eff) begin
                w_dn[i] = 1'b1;
            end else begin
                w_hold[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [SW-1:0] w_lo, w_hi;
        if (g == 0) begin : g_lo_edge
            assign w_lo = '0;
        end else begin : g_lo_nb
            assign w_lo = w_slot[g-1];
        end
        if (g == DEPTH - 1) begin : g_hi_edge
            assign w_hi = '0;
        end else begin : g_hi_nb
            assign w_hi = w_slot[g+1];
        end

        pifo_slot #(
            .RANK_WIDTH (RANK_WIDTH),
            .META_WIDTH (META_WIDTH)
        ) u_slot (
            .clk          (clk),
            .i_hold       (w_hold[g]),
            .i_shift_up   (w_up[g]),
            .i_shift_down (w_dn[g]),
            .i_load_new   (w_load[g]),
            .i_clear      (w_clr[g]),
            .i_lo         (w_lo),
            .i_hi         (w_hi),
            .i_new        (w_new),
            .o_slot       (w_slot[g]),
            .o_le_c       (w_le[g])
        );
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_ins && !w_deq_eff) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_ins && w_deq_eff) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign count     = r_count;
    assign full      = r_full;
    assign valid_out = w_slot[0][SW-1];
    assign rank_out  = w_slot[0][RANK_WIDTH+META_WIDTH-1:META_WIDTH];
    assign meta_out  = w_slot[0][META_WIDTH-1:0];

endmodule

// File: tb/tb_pifo_reg_sorter.sv
// Directed bench for pifo_reg_sorter with hand-computed expected values.
module tb_pifo_reg_sorter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] rank_in;
    logic [15:0] meta_in;
    logic        in_remove;
    logic        deq;
    logic        valid_out;
    logic [15:0] rank_out;
    logic [15:0] meta_out;
    logic        full;
    logic [4:0]  count;

    int n_chk;
    int n_err;

    pifo_reg_sorter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .rank_in   (rank_in),
        .meta_in   (meta_in),
        .in_remove (in_remove),
        .deq       (deq),
        .valid_out (valid_out),
        .rank_out  (rank_out),
        .meta_out  (meta_out),
        .full      (full),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] r, input logic [15:0] m);
        in_valid = 1'b1;
        rank_in  = r;
        meta_in  = m;
        deq      = 1'b0;
        tick();
        in_valid = 1'b0;
    endtask

    int          exp_rank [4];
    int          exp_meta [4];
    int          drain_rank [16];
    int          drain_meta [16];

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst      = 1'b0;
        in_valid = 1'b1;
        deq      = 1'b1;
        rank_in  = 16'd3;
        meta_in  = 16'd3;
        #1;
        chk("in_remove_in_reset", 32'(in_remove), 0);
        tick();
        tick();
        in_valid = 1'b0;
        deq      = 1'b0;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_rank", 32'(rank_out), 0);
        chk("rst_meta", 32'(meta_out), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b1;
        tick();

        // Ordered insert with tie kept in arrival order.
        exp_rank = '{2, 2, 5, 9};
        exp_meta = '{2, 4, 1, 3};
        begin
            int rk [4];
            int mt [4];
            rk = '{5, 2, 9, 2};
            mt = '{1, 2, 3, 4};
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                rank_in  = 16'(rk[i]);
                meta_in  = 16'(mt[i]);
                #1;
                chk("ins_remove", 32'(in_remove), 1);
                tick();
                chk("ins_count", 32'(count), 32'(i + 1));
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("deq_valid", 32'(valid_out), 1);
            chk("deq_rank", 32'(rank_out), 32'(exp_rank[i]));
            chk("deq_meta", 32'(meta_out), 32'(exp_meta[i]));
            deq = 1'b1;
            tick();
            deq = 1'b0;
            chk("deq_count", 32'(count), 32'(3 - i));
        end
        chk("empty_valid", 32'(valid_out), 0);

        // Fill, then back-pressure while full, then insert+deq at full.
        for (int i = 0; i < 16; i++) push(16'(i), 16'(100 + i));
        chk("fill_count", 32'(count), 16);
        chk("fill_full", 32'(full), 1);
        in_valid = 1'b1;
        rank_in  = 16'd7;
        meta_in  = 16'd77;
        #1;
        chk("full_hold_remove", 32'(in_remove), 0);
        tick();
        chk("full_hold_count", 32'(count), 16);
        chk("full_hold_head", 32'(rank_out), 0);
        deq = 1'b1;
        #1;
        chk("full_deq_remove", 32'(in_remove), 1);
        tick();
        deq      = 1'b0;
        in_valid = 1'b0;
        chk("full_deq_count", 32'(count), 16);
        chk("full_deq_full", 32'(full), 1);
        chk("full_deq_head", 32'(rank_out), 1);
        for (int i = 0; i < 16; i++) begin
            if (i < 7) begin
                drain_rank[i] = i + 1;
                drain_meta[i] = 101 + i;
            end else if (i == 7) begin
                drain_rank[i] = 7;
                drain_meta[i] = 77;
            end else begin
                drain_rank[i] = i;
                drain_meta[i] = 100 + i;
            end
        end
        for (int i = 0; i < 16; i++) begin
            chk("drain_rank", 32'(rank_out), 32'(drain_rank[i]));
            chk("drain_meta", 32'(meta_out), 32'(drain_meta[i]));
            deq = 1'b1;
            tick();
            deq = 1'b0;
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_full", 32'(full), 0);

        // Simultaneous insert and dequeue.
        push(16'd4, 16'd40);
        push(16'd6, 16'd60);
        in_valid = 1'b1;
        rank_in  = 16'd3;
        meta_in  = 16'd30;
        deq      = 1'b1;
        tick();
        in_valid = 1'b0;
        deq      = 1'b0;
        chk("mix3_head", 32'(rank_out), 3);
        chk("mix3_meta", 32'(meta_out), 30);
        chk("mix3_count", 32'(count), 2);
        deq = 1'b1;
        tick();
        deq = 1'b0;
        chk("mix3_next", 32'(rank_out), 6);
        push(16'd4, 16'd41);
        chk("mix5_pre_head", 32'(rank_out), 4);
        in_valid = 1'b1;
        rank_in  = 16'd5;
        meta_in  = 16'd50;
        deq      = 1'b1;
        tick();
        in_valid = 1'b0;
        deq      = 1'b0;
        chk("mix5_head", 32'(rank_out), 5);
        chk("mix5_count", 32'(count), 2);
        deq = 1'b1;
        tick();
        chk("mix5_next", 32'(rank_out), 6);
        chk("mix5_next_meta", 32'(meta_out), 60);
        tick();
        deq = 1'b0;
        chk("mix_empty_count", 32'(count), 0);

        // Dequeue on empty is ignored.
        deq = 1'b1;
        tick();
        deq = 1'b0;
        chk("emptydeq_valid", 32'(valid_out), 0);
        chk("emptydeq_count", 32'(count), 0);
        chk("emptydeq_rank", 32'(rank_out), 0);

        // Insert with deq on empty queue.
        in_valid = 1'b1;
        rank_in  = 16'd1;
        meta_in  = 16'd11;
        deq      = 1'b1;
        #1;
        chk("emptyins_remove", 32'(in_remove), 1);
        tick();
        in_valid = 1'b0;
        deq      = 1'b0;
        chk("emptyins_count", 32'(count), 1);
        chk("emptyins_head", 32'(rank_out), 1);

        // Mid-operation reset.
        push(16'd8, 16'd80);
        push(16'd3, 16'd31);
        chk("prerst_count", 32'(count), 3);
        rst      = 1'b0;
        in_valid = 1'b1;
        rank_in  = 16'd2;
        meta_in  = 16'd22;
        deq      = 1'b1;
        #1;
        chk("midrst_remove", 32'(in_remove), 0);
        tick();
        chk("midrst_count", 32'(count), 0);
        chk("midrst_valid", 32'(valid_out), 0);
        chk("midrst_rank", 32'(rank_out), 0);
        rst = 1'b1;
        deq = 1'b0;
        #1;
        chk("postrst_remove", 32'(in_remove), 1);
        tick();
        in_valid = 1'b0;
        chk("postrst_count", 32'(count), 1);
        chk("postrst_head", 32'(rank_out), 2);
        chk("postrst_meta", 32'(meta_out), 22);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
